// File: rtl/cmd_word_sequencer_if.sv
// cmd_word_sequencer_if: host bus, priority-logic inputs and command-word outputs of the sequencer.
interface cmd_word_sequencer_if #(parameter int NUM_IRQ = 8);
    logic               cs_n, wr_n, rd_n, a0;
    logic [7:0]         din;
    logic [NUM_IRQ-1:0] irr, isr;
    logic [7:0]         icw1, icw2, icw3, icw4, ocw2, ocw3;
    logic [NUM_IRQ-1:0] ocw1;
    logic               init_done, ocw2_stb, ocw3_stb, icw1_stb;
    logic [7:0]         dout;
    logic               dout_oe, seq_err;
    modport master (
        output cs_n, wr_n, rd_n, a0, din, irr, isr,
        input  icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, init_done,
               ocw2_stb, ocw3_stb, icw1_stb, dout, dout_oe, seq_err
    );
    modport slave (
        input  cs_n, wr_n, rd_n, a0, din, irr, isr,
        output icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, init_done,
               ocw2_stb, ocw3_stb, icw1_stb, dout, dout_oe, seq_err
    );
endinterface

// File: rtl/cmd_word_sequencer.sv
// cmd_word_sequencer: decodes ICW/OCW writes from an asynchronous host bus and serves IMR/IRR/ISR reads.
module cmd_word_sequencer #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst_n,
    cmd_word_sequencer_if.slave bus
);
    localparam int BYTES = NUM_IRQ / 8;
    typedef enum logic [2:0] {UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] cs_sr, wr_sr, rd_sr, a0_sr;
    logic [7:0] din_sr [SYNC_STAGES];
    logic cs_s, wr_s, rd_s, a0_s;
    logic [7:0] din_s, din_l, rd_byte;
    logic wr_q, rd_q, conf_q, wr_pend, a0_l, wptr, rptr, rsel;
    logic conflict, commit, rd_start, rd_end, rd_cancel;
    logic [NUM_IRQ-1:0] src;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cs_sr <= '1;
            wr_sr <= '1;
            rd_sr <= '1;
            a0_sr <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) din_sr[i] <= '0;
        end else begin
            cs_sr <= {cs_sr[SYNC_STAGES-2:0], bus.cs_n};
            wr_sr <= {wr_sr[SYNC_STAGES-2:0], bus.wr_n};
            rd_sr <= {rd_sr[SYNC_STAGES-2:0], bus.rd_n};
            a0_sr <= {a0_sr[SYNC_STAGES-2:0], bus.a0};
            din_sr[0] <= bus.din;
            for (int i = 1; i < SYNC_STAGES; i++) din_sr[i] <= din_sr[i-1];
        end
    assign cs_s  = cs_sr[SYNC_STAGES-1];
    assign wr_s  = wr_sr[SYNC_STAGES-1];
    assign rd_s  = rd_sr[SYNC_STAGES-1];
    assign a0_s  = a0_sr[SYNC_STAGES-1];
    assign din_s = din_sr[SYNC_STAGES-1];
    // a write only commits if its whole low phase ran under chip select without a read overlapping it
    assign conflict  = !wr_s && !rd_s;
    assign commit    = wr_pend && wr_s && !cs_s;
    assign rd_start  = rd_q && !rd_s && !cs_s && wr_s;
    assign rd_cancel = bus.dout_oe && cs_s;
    assign rd_end    = bus.dout_oe && rd_s && !rd_q;
    assign src       = a0_s ? bus.ocw1 : rsel ? bus.isr : bus.irr;
    assign rd_byte   = (rptr && BYTES > 1) ? src[NUM_IRQ-1 -: 8] : src[7:0];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= UNINIT;
            {bus.icw1, bus.icw2, bus.icw3, bus.icw4, bus.ocw2, bus.ocw3} <= '0;
            bus.ocw1 <= '0;
            {bus.init_done, bus.ocw2_stb, bus.ocw3_stb, bus.icw1_stb, bus.seq_err, bus.dout_oe} <= '0;
            bus.dout <= '0;
            {wptr, rptr, rsel, conf_q, wr_pend, a0_l} <= '0;
            {wr_q, rd_q} <= 2'b11;
            din_l <= '0;
        end else begin
            wr_q <= wr_s;
            rd_q <= rd_s;
            conf_q <= conflict;
            if (!wr_s) {a0_l, din_l} <= {a0_s, din_s};
            wr_pend <= !wr_s && !cs_s && !conflict && (wr_q || wr_pend);
            {bus.icw1_stb, bus.ocw2_stb, bus.ocw3_stb} <= '0;
            bus.seq_err <= conflict && !conf_q;
            if (rd_start) begin
                bus.dout <= rd_byte;
                bus.dout_oe <= 1'b1;
            end else if (rd_cancel) bus.dout_oe <= 1'b0;
            else if (rd_end) begin
                bus.dout_oe <= 1'b0;
                rptr <= BYTES > 1 ? !rptr : 1'b0;
            end
            if (commit) begin
                if (!a0_l) {wptr, rptr} <= '0;
                if (!a0_l && din_l[4]) begin
                    bus.icw1 <= din_l;
                    bus.icw1_stb <= 1'b1;
                    bus.ocw1 <= '0;
                    bus.icw4 <= '0;
                    rsel <= 1'b0;
                    bus.init_done <= 1'b0;
                    state <= WAIT_ICW2;
                end else if (state == READY) begin
                    if (a0_l) begin
                        if (wptr && BYTES > 1) bus.ocw1[NUM_IRQ-1 -: 8] <= din_l;
                        else bus.ocw1[7:0] <= din_l;
                        wptr <= BYTES > 1 ? !wptr : 1'b0;
                    end else if (!din_l[3]) begin
                        bus.ocw2 <= din_l;
                        bus.ocw2_stb <= 1'b1;
                    end else begin
                        bus.ocw3 <= din_l;
                        bus.ocw3_stb <= 1'b1;
                        if (din_l[1]) rsel <= din_l[0];
                    end
                end else if (!a0_l || state == UNINIT) bus.seq_err <= 1'b1;
                else if (state == WAIT_ICW2) begin
                    bus.icw2 <= din_l;
                    state <= !bus.icw1[1] ? WAIT_ICW3 : bus.icw1[0] ? WAIT_ICW4 : READY;
                    bus.init_done <= bus.icw1[1] && !bus.icw1[0];
                end else if (state == WAIT_ICW3) begin
                    bus.icw3 <= din_l;
                    state <= bus.icw1[0] ? WAIT_ICW4 : READY;
                    bus.init_done <= !bus.icw1[0];
                end else begin
                    bus.icw4 <= din_l;
                    state <= READY;
                    bus.init_done <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_cmd_word_sequencer.sv
// tb_cmd_word_sequencer: directed and randomized checks of the 16-line sequencer against a queue-based model.
module tb_cmd_word_sequencer;
    logic clk = 0, rst_n = 0;
    int total = 0, bad = 0;
    int c_icw1 = 0, c_ocw2 = 0, c_ocw3 = 0, c_err = 0;
    int e_icw1 = 0, e_ocw2 = 0, e_ocw3 = 0, e_err = 0;
    logic [7:0] m_icw [1:4];
    logic [7:0] m_ocw2, m_ocw3;
    logic [15:0] m_imr;
    bit m_done, m_sel;
    int need [$];
    int wp, rp;

    cmd_word_sequencer_if #(.NUM_IRQ(16)) bus ();
    cmd_word_sequencer #(.NUM_IRQ(16), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.icw1_stb) c_icw1++;
        if (bus.ocw2_stb) c_ocw2++;
        if (bus.ocw3_stb) c_ocw3++;
        if (bus.seq_err) c_err++;
    end

    task automatic m_reset();
        for (int i = 1; i <= 4; i++) m_icw[i] = 0;
        m_ocw2 = 0; m_ocw3 = 0; m_imr = 0; m_done = 0; m_sel = 0; wp = 0; rp = 0;
        need.delete();
    endtask

    // ICW1 queues the remaining init words; the model is "initialised" once that queue drains
    task automatic m_write(input bit a, input logic [7:0] d);
        int k;
        if (!a) begin wp = 0; rp = 0; end
        if (!a && d[4]) begin
            m_icw[1] = d; m_icw[4] = 0; m_imr = 0; m_sel = 0; m_done = 0; e_icw1++;
            need = {2};
            if (!d[1]) need.push_back(3);
            if (d[0]) need.push_back(4);
        end else if (!a) begin
            if (!m_done) e_err++;
            else if (!d[3]) begin m_ocw2 = d; e_ocw2++; end
            else begin m_ocw3 = d; e_ocw3++; if (d[1]) m_sel = d[0]; end
        end else if (m_done) begin
            m_imr[wp*8 +: 8] = d; wp = (wp + 1) % 2;
        end else if (need.size() == 0) e_err++;
        else begin
            k = need.pop_front(); m_icw[k] = d; m_done = (need.size() == 0);
        end
    endtask

    function automatic logic [7:0] m_rd(input bit a, input bit adv);
        logic [15:0] s;
        s = a ? m_imr : (m_sel ? bus.isr : bus.irr);
        m_rd = s[rp*8 +: 8];
        if (adv) rp = (rp + 1) % 2;
    endfunction

    task automatic wr(input bit a, input logic [7:0] d);
        @(negedge clk); bus.cs_n = 0; bus.a0 = a; bus.din = d;
        repeat (2) @(negedge clk); bus.wr_n = 0;
        repeat (3) @(negedge clk); bus.wr_n = 1;
        repeat (4) @(negedge clk); bus.cs_n = 1;
        repeat (4) @(negedge clk);
        m_write(a, d);
    endtask

    task automatic rd(input bit a, output logic [7:0] got, output logic oe_on, output logic oe_off);
        @(negedge clk); bus.cs_n = 0; bus.a0 = a;
        repeat (2) @(negedge clk); bus.rd_n = 0;
        repeat (4) @(negedge clk); oe_on = bus.dout_oe; got = bus.dout; bus.rd_n = 1;
        repeat (4) @(negedge clk); oe_off = bus.dout_oe; bus.cs_n = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        m_reset();
        repeat (3) @(negedge clk);
        total++; if ({bus.icw1, bus.icw2, bus.icw3, bus.icw4} !== 32'h0) begin bad++; $display("FAIL reset_icw got=%h exp=0", {bus.icw1, bus.icw2, bus.icw3, bus.icw4}); end
        total++; if ({bus.ocw1, bus.ocw2, bus.ocw3} !== 32'h0) begin bad++; $display("FAIL reset_ocw got=%h exp=0", {bus.ocw1, bus.ocw2, bus.ocw3}); end
        total++; if ({bus.init_done, bus.dout_oe, bus.seq_err, bus.dout} !== 11'h0) begin bad++; $display("FAIL reset_misc got=%h exp=0", {bus.init_done, bus.dout_oe, bus.seq_err, bus.dout}); end
        rst_n = 1;
        repeat (3) @(negedge clk);
        wr(1, 8'h5A);
        total++; if (c_err !== e_err || e_err != 1) begin bad++; $display("FAIL uninit_a0_1 seq_err got=%0d exp=%0d", c_err, e_err); end
        total++; if (bus.icw2 !== 8'h00) begin bad++; $display("FAIL uninit_a0_1 icw2 got=%h exp=00", bus.icw2); end
    endtask

    task automatic test_icw_single();
        wr(0, 8'h13);
        total++; if (bus.icw1 !== 8'h13 || c_icw1 !== e_icw1) begin bad++; $display("FAIL single_icw1 got=%h/%0d exp=13/%0d", bus.icw1, c_icw1, e_icw1); end
        wr(1, 8'h20);
        total++; if (bus.init_done !== 1'b0) begin bad++; $display("FAIL single_early_done got=%b exp=0", bus.init_done); end
        wr(1, 8'h01);
        total++; if ({bus.icw2, bus.icw3, bus.icw4} !== 24'h200001) begin bad++; $display("FAIL single_icws got=%h exp=200001", {bus.icw2, bus.icw3, bus.icw4}); end
        total++; if (bus.init_done !== 1'b1) begin bad++; $display("FAIL single_done got=%b exp=1", bus.init_done); end
    endtask

    task automatic test_icw_cascade();
        wr(0, 8'h11);
        wr(1, 8'h08);
        total++; if (bus.init_done !== 1'b0) begin bad++; $display("FAIL cascade_done_icw2 got=%b exp=0", bus.init_done); end
        wr(1, 8'h04);
        total++; if (bus.init_done !== 1'b0) begin bad++; $display("FAIL cascade_done_icw3 got=%b exp=0", bus.init_done); end
        wr(1, 8'h03);
        total++; if ({bus.icw1, bus.icw2, bus.icw3, bus.icw4} !== 32'h11080403) begin bad++; $display("FAIL cascade_icws got=%h exp=11080403", {bus.icw1, bus.icw2, bus.icw3, bus.icw4}); end
        total++; if (bus.init_done !== 1'b1) begin bad++; $display("FAIL cascade_done got=%b exp=1", bus.init_done); end
    endtask

    task automatic test_mask16();
        logic [7:0] g; logic on, off;
        wr(1, 8'hAA);
        wr(1, 8'h55);
        total++; if (bus.ocw1 !== 16'h55AA) begin bad++; $display("FAIL mask_ocw1 got=%h exp=55aa", bus.ocw1); end
        rd(1, g, on, off);
        total++; if (g !== 8'hAA || on !== 1'b1 || off !== 1'b0) begin bad++; $display("FAIL mask_rd0 got=%h oe=%b%b exp=aa oe=10", g, on, off); end
        rd(1, g, on, off);
        total++; if (g !== 8'h55 || on !== 1'b1 || off !== 1'b0) begin bad++; $display("FAIL mask_rd1 got=%h oe=%b%b exp=55 oe=10", g, on, off); end
        rp = 0;
    endtask

    task automatic test_ocw3_read();
        logic [7:0] g; logic on, off;
        bus.isr = 16'h0004; bus.irr = 16'h0080;
        wr(0, 8'h0B);
        total++; if (bus.ocw3 !== 8'h0B || c_ocw3 !== 1) begin bad++; $display("FAIL ocw3_load got=%h/%0d exp=0b/1", bus.ocw3, c_ocw3); end
        rd(0, g, on, off);
        total++; if (g !== 8'h04 || on !== 1'b1) begin bad++; $display("FAIL ocw3_isr got=%h oe=%b exp=04 oe=1", g, on); end
        wr(0, 8'h0A);
        rd(0, g, on, off);
        total++; if (g !== 8'h80) begin bad++; $display("FAIL ocw3_irr got=%h exp=80", g); end
        rp = 0;
        wr(0, 8'h05);
        total++; if (bus.ocw2 !== 8'h05 || c_ocw2 !== 1) begin bad++; $display("FAIL ocw2_load got=%h/%0d exp=05/1", bus.ocw2, c_ocw2); end
    endtask

    task automatic test_seq_err();
        wr(0, 8'h13);
        total++; if (bus.ocw1 !== 16'h0 || bus.init_done !== 1'b0) begin bad++; $display("FAIL restart_clear got=%h/%b exp=0000/0", bus.ocw1, bus.init_done); end
        wr(0, 8'h20);
        total++; if (c_err !== e_err) begin bad++; $display("FAIL wait_icw2_err got=%0d exp=%0d", c_err, e_err); end
        wr(1, 8'h42);
        total++; if (bus.icw2 !== 8'h42) begin bad++; $display("FAIL wait_icw2_kept got=%h exp=42", bus.icw2); end
        wr(0, 8'h13);
        wr(1, 8'h21);
        wr(1, 8'h01);
        total++; if (bus.icw2 !== 8'h21 || bus.init_done !== 1'b1 || bus.ocw1 !== 16'h0) begin bad++; $display("FAIL mid_restart got=%h/%b/%h exp=21/1/0000", bus.icw2, bus.init_done, bus.ocw1); end
    endtask

    task automatic test_cancel_conflict();
        logic [7:0] ex;
        wr(1, 8'h3C);
        @(negedge clk); bus.cs_n = 0; bus.a0 = 1; bus.din = 8'hEE;
        repeat (2) @(negedge clk); bus.wr_n = 0;
        repeat (3) @(negedge clk); bus.cs_n = 1;
        repeat (4) @(negedge clk); bus.wr_n = 1;
        repeat (4) @(negedge clk);
        total++; if (bus.ocw1 !== m_imr) begin bad++; $display("FAIL cs_cancel_wr got=%h exp=%h", bus.ocw1, m_imr); end
        ex = m_rd(1, 0);
        @(negedge clk); bus.cs_n = 0;
        repeat (2) @(negedge clk); bus.rd_n = 0;
        repeat (4) @(negedge clk);
        total++; if (bus.dout_oe !== 1'b1 || bus.dout !== ex) begin bad++; $display("FAIL cs_cancel_rd_on got=%h/%b exp=%h/1", bus.dout, bus.dout_oe, ex); end
        bus.cs_n = 1;
        repeat (4) @(negedge clk);
        total++; if (bus.dout_oe !== 1'b0) begin bad++; $display("FAIL cs_cancel_rd_off got=%b exp=0", bus.dout_oe); end
        bus.rd_n = 1;
        repeat (3) @(negedge clk); bus.cs_n = 0; bus.din = 8'h77;
        repeat (2) @(negedge clk); bus.wr_n = 0; bus.rd_n = 0;
        repeat (4) @(negedge clk);
        total++; if (bus.dout_oe !== 1'b0) begin bad++; $display("FAIL conflict_oe got=%b exp=0", bus.dout_oe); end
        bus.wr_n = 1; bus.rd_n = 1;
        repeat (4) @(negedge clk); bus.cs_n = 1;
        repeat (4) @(negedge clk);
        e_err++;
        total++; if (c_err !== e_err || bus.ocw1 !== m_imr) begin bad++; $display("FAIL conflict got=%0d/%h exp=%0d/%h", c_err, bus.ocw1, e_err, m_imr); end
    endtask

    task automatic test_random();
        logic [7:0] g, d, ex; logic on, off; bit a;
        for (int n = 0; n < 60; n++) begin
            a = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 3) begin
                bus.irr = 16'($urandom); bus.isr = 16'($urandom);
                ex = m_rd(a, 1);
                rd(a, g, on, off);
                total++; if (g !== ex || on !== 1'b1 || off !== 1'b0) begin bad++; $display("FAIL rnd_rd[%0d] got=%h oe=%b%b exp=%h oe=10", n, g, on, off, ex); end
            end else begin
                d = 8'($urandom);
                if (!a && $urandom_range(0, 3) != 0) d[4] = 0;
                wr(a, d);
                total++; if ({bus.icw1, bus.icw2, bus.icw3, bus.icw4} !== {m_icw[1], m_icw[2], m_icw[3], m_icw[4]})
                    begin bad++; $display("FAIL rnd_icw[%0d] got=%h exp=%h", n, {bus.icw1, bus.icw2, bus.icw3, bus.icw4}, {m_icw[1], m_icw[2], m_icw[3], m_icw[4]}); end
                total++; if ({bus.ocw1, bus.ocw2, bus.ocw3, bus.init_done} !== {m_imr, m_ocw2, m_ocw3, m_done})
                    begin bad++; $display("FAIL rnd_ocw[%0d] got=%h exp=%h", n, {bus.ocw1, bus.ocw2, bus.ocw3, bus.init_done}, {m_imr, m_ocw2, m_ocw3, m_done}); end
                total++; if ({c_icw1, c_ocw2, c_ocw3, c_err} !== {e_icw1, e_ocw2, e_ocw3, e_err})
                    begin bad++; $display("FAIL rnd_pulses[%0d] got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", n, c_icw1, c_ocw2, c_ocw3, c_err, e_icw1, e_ocw2, e_ocw3, e_err); end
            end
        end
    endtask

    task automatic test_async_reset();
        wr(0, 8'h13); wr(1, 8'h20); wr(1, 8'h01); wr(1, 8'hC3);
        @(negedge clk); bus.cs_n = 0; bus.a0 = 1;
        repeat (2) @(negedge clk); bus.rd_n = 0;
        repeat (4) @(negedge clk);
        total++; if (bus.dout_oe !== 1'b1 || bus.init_done !== 1'b1) begin bad++; $display("FAIL pre_reset got=%b/%b exp=1/1", bus.dout_oe, bus.init_done); end
        #2 rst_n = 0;
        #1;
        total++; if ({bus.dout_oe, bus.init_done, bus.dout, bus.ocw1, bus.icw1} !== 34'h0) begin bad++; $display("FAIL async_reset got=%h exp=0", {bus.dout_oe, bus.init_done, bus.dout, bus.ocw1, bus.icw1}); end
        bus.cs_n = 1; bus.rd_n = 1;
        repeat (2) @(negedge clk); rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.cs_n = 1; bus.wr_n = 1; bus.rd_n = 1; bus.a0 = 0; bus.din = 0; bus.irr = 0; bus.isr = 0;
        test_reset();
        test_icw_single();
        test_icw_cascade();
        test_mask16();
        test_ocw3_read();
        test_seq_err();
        test_cancel_conflict();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmd_word_sequencer.md
CMD_WORD_SEQUENCER -- requirements
Module: cmd_word_sequencer

Interface
REQ-001 Parameter NUM_IRQ, default 8; interrupt line count and mask/IRR/ISR width; legal values 8 or 16 only.
REQ-002 Parameter SYNC_STAGES, default 2; synchroniser depth on cs_n, wr_n, rd_n, a0 and din; legal 2..4.
REQ-003 Derived BYTES = NUM_IRQ/8.
REQ-004 Clock and reset: one clock, reset asynchronous active-low; clk in 1, rising-edge system clock; rst_n in 1, asynchronous active-low reset.
REQ-005 cs_n in 1, chip select, active low; wr_n in 1, write strobe, active low; rd_n in 1, read strobe, active low; a0 in 1, register address bit.
REQ-006 din in 8, bus write data; irr in NUM_IRQ, request register from priority logic; isr in NUM_IRQ, in-service register from priority logic.
REQ-007 icw1, icw2, icw3, icw4, ocw2, ocw3 out 8 each, latched command words; ocw1 out NUM_IRQ, interrupt mask (IMR).
REQ-008 init_done out 1, initialisation sequence complete; ocw2_stb out 1, one-cycle pulse on OCW2 commit; ocw3_stb out 1, one-cycle pulse on OCW3 commit; icw1_stb out 1, one-cycle pulse on ICW1 commit.
REQ-009 dout out 8, read data; dout_oe out 1, read data valid/drive enable; seq_err out 1, one-cycle pulse on rejected access.

Function
REQ-010 All bus inputs pass through SYNC_STAGES flops before use; "_s" denotes synchronised versions.
REQ-011 Write commit: rising edge of wr_n_s (0 to 1) while cs_n_s low; a0 and din sampled in the last cycle wr_n_s was low.
REQ-012 Read start: falling edge of rd_n_s while cs_n_s low; read end: rising edge of rd_n_s.
REQ-013 rd_n_s and wr_n_s both low in the same cycle: the write commit and read start in that cycle are both suppressed, and seq_err pulses.
REQ-014 FSM states: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
REQ-015 ICW1 decode (a0=0, din[4]=1) is accepted in any state: load icw1, pulse icw1_stb, clear ocw1 to 0, clear icw4 to 0, clear read-select to IRR, clear init_done, next state WAIT_ICW2.
REQ-016 WAIT_ICW2, a0=1: load icw2; next state WAIT_ICW3 if icw1[1]=0, else WAIT_ICW4 if icw1[0]=1, else READY.
REQ-017 WAIT_ICW3, a0=1: load icw3; next state WAIT_ICW4 if icw1[0]=1, else READY.
REQ-018 WAIT_ICW4, a0=1: load icw4; next state READY.
REQ-019 init_done is set on entry to READY and held until reset or the next ICW1.
REQ-020 In UNINIT or any WAIT_* state, an a0=0 non-ICW1 write is discarded, state is unchanged, and seq_err pulses; in UNINIT, an a0=1 write is discarded and seq_err pulses.
REQ-021 READY, a0=1: write din into byte wptr of ocw1; wptr increments, wrapping at BYTES-1; with BYTES=1, wptr is always 0.
REQ-022 READY, a0=0, din[4:3]=00: load ocw2 and pulse ocw2_stb in the cycle after commit.
REQ-023 READY, a0=0, din[4:3]=01: load ocw3 and pulse ocw3_stb; if din[1]=1, read-select becomes ISR when din[0]=1, else IRR; if din[1]=0, read-select is unchanged.
REQ-024 Every committed a0=0 write clears wptr and rptr to 0.
REQ-025 Read source at read start: a0=1 selects ocw1; a0=0 selects irr or isr per read-select.
REQ-026 At read start, dout latches byte rptr of the selected source; dout_oe goes high one cycle after read start and stays high until read end.
REQ-027 At read end, rptr increments, wrapping at BYTES-1; reads do not depend on FSM state.
REQ-028 Strobe and error pulses are exactly one clk wide and never overlap the same commit twice.
REQ-029 cs_n_s rising mid-strobe cancels the pending commit or read end with no register change; dout_oe drops the next cycle.

Reset
REQ-030 rst_n low asynchronously forces: state UNINIT; all command-word outputs 0; init_done 0; all strobes 0; seq_err 0; dout 0; dout_oe 0; wptr and rptr 0; read-select IRR; all synchroniser flops to idle (cs_n, wr_n, rd_n = 1).
REQ-031 Reset deassertion mid-strobe produces no commit until a full low-to-high wr_n_s cycle is observed.

Verification
REQ-032 Write ICW1=0x13, then ICW2=0x20, then ICW4=0x01 (single mode, IC4 set) -> icw3 stays 0x00, init_done=1 after the third commit, state READY.
REQ-033 Write ICW1=0x11, then ICW2=0x08, then ICW3=0x04, then ICW4=0x03 -> all four ICW registers hold those values; init_done rises only after ICW4.
REQ-034 With NUM_IRQ=16 in READY, write a0=1 0xAA then a0=1 0x55 -> ocw1=0x55AA; two a0=1 reads -> dout 0xAA then 0x55.
REQ-035 In READY, write OCW3=0x0B with isr=0x04 and irr=0x80, then read a0=0 -> dout=0x04, one ocw3_stb pulse; then write OCW3=0x0A and read -> dout=0x80.
REQ-036 In WAIT_ICW2, write a0=0 0x20 -> seq_err pulses once and state is unchanged; then write ICW1=0x13 mid-sequence -> restart, ocw1=0.
REQ-037 Assert rst_n low during an active read with dout_oe=1 -> dout_oe=0 and state UNINIT immediately, without waiting for a clk edge.
